tensor_thread_group: RTL and testbench

TENSOR_THREAD_GROUP -- requirements
Module: tensor_thread_group

---
 rtl/tensor_pkg.sv | 19 +
 rtl/tensor_thread_group_if.sv | 33 +++
 rtl/tensor_thread_group_dot_lane.sv | 72 +++++++
 rtl/tensor_thread_group.sv | 103 ++++++++++
 tb/tb_tensor_thread_group.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tensor_pkg.sv
// Shared definitions for the tensor thread group: element width default and the
// pipeline-entry layout at default geometry.
package tensor_pkg;

   localparam int XLEN_DEFAULT       = 32;
   localparam int GROUP_SIZE_DEFAULT = 4;
   localparam int RD_W_DEFAULT       = 4;

   // One request as it enters the dot-product pipeline.
   typedef struct packed {
      logic                                                       valid;
      logic                                                       wb;
      logic [RD_W_DEFAULT-1:0]                                    rd;
      logic [GROUP_SIZE_DEFAULT*XLEN_DEFAULT-1:0]                 acc;
      logic [GROUP_SIZE_DEFAULT*XLEN_DEFAULT-1:0]                 a;
      logic [GROUP_SIZE_DEFAULT*GROUP_SIZE_DEFAULT*XLEN_DEFAULT-1:0] b;
   } pipe_entry_t;

endpackage

// File: rtl/tensor_thread_group_if.sv
// Request/result handshake bundle between a requester (master) and the thread group (slave).
interface tensor_thread_group_if
   import tensor_pkg::*;
#(
   parameter int XLEN       = XLEN_DEFAULT,
   parameter int GROUP_SIZE = GROUP_SIZE_DEFAULT,
   parameter int RD_W       = RD_W_DEFAULT
);

   logic                                 valid_in;
   logic                                 ready_in;
   logic [GROUP_SIZE*XLEN-1:0]           vec_a_in;
   logic [GROUP_SIZE*GROUP_SIZE*XLEN-1:0] vec_b_in;
   logic [GROUP_SIZE*XLEN-1:0]           vec_c_in;
   logic                                 acc_sel;
   logic                                 wb;
   logic [RD_W-1:0]                      rd;
   logic                                 valid_out;
   logic                                 ready_out;
   logic [GROUP_SIZE*XLEN-1:0]           vec_d_out;
   logic [RD_W-1:0]                      rd_out;

   modport master (
      output valid_in, vec_a_in, vec_b_in, vec_c_in, acc_sel, wb, rd, ready_out,
      input  ready_in, valid_out, vec_d_out, rd_out
   );

   modport slave (
      input  valid_in, vec_a_in, vec_b_in, vec_c_in, acc_sel, wb, rd, ready_out,
      output ready_in, valid_out, vec_d_out, rd_out
   );

endinterface

// File: rtl/tensor_thread_group_dot_lane.sv
// One lane of the group: acc + sum_k a[k]*b[k], wrapping mod 2^XLEN, over DOT_LAT
// stall-able stages (products first, then the reduction, then delay).
module dot_lane #(
   parameter int XLEN       = 32,
   parameter int GROUP_SIZE = 4,
   parameter int DOT_LAT    = 2
) (
   input  logic                       clk,
   input  logic                       stall,
   input  logic [GROUP_SIZE*XLEN-1:0] a,
   input  logic [GROUP_SIZE*XLEN-1:0] b,
   input  logic [XLEN-1:0]            acc,
   output logic [XLEN-1:0]            d
);

   function automatic logic [GROUP_SIZE*XLEN-1:0] mul_terms(
      input logic [GROUP_SIZE*XLEN-1:0] x,
      input logic [GROUP_SIZE*XLEN-1:0] y
   );
      logic [GROUP_SIZE*XLEN-1:0] p;
      p = '0;
      for (int k = 0; k < GROUP_SIZE; k++)
         p[k*XLEN +: XLEN] = x[k*XLEN +: XLEN] * y[k*XLEN +: XLEN];
      return p;
   endfunction

   function automatic logic [XLEN-1:0] sum_terms(
      input logic [XLEN-1:0]            base,
      input logic [GROUP_SIZE*XLEN-1:0] terms
   );
      logic [XLEN-1:0] s;
      s = base;
      for (int k = 0; k < GROUP_SIZE; k++)
         s = s + terms[k*XLEN +: XLEN];
      return s;
   endfunction

   if (DOT_LAT == 1) begin : g_single
      logic [XLEN-1:0] sum_p0;

      // p0: full multiply-accumulate in one stage
      always_ff @(posedge clk) begin
         if (!stall) sum_p0 <= sum_terms(acc, mul_terms(a, b));
      end

      assign d = sum_p0;
   end else begin : g_multi
      logic [GROUP_SIZE*XLEN-1:0] prod_p0;
      logic [XLEN-1:0]            acc_p0;
      logic [XLEN-1:0]            sum_p [DOT_LAT-1];

      // p0: products and accumulator operand
      always_ff @(posedge clk) begin
         if (!stall) begin
            prod_p0 <= mul_terms(a, b);
            acc_p0  <= acc;
         end
      end

      // p1..: reduction, then pure delay to the final stage
      always_ff @(posedge clk) begin
         if (!stall) begin
            sum_p[0] <= sum_terms(acc_p0, prod_p0);
            for (int s = 1; s < DOT_LAT - 1; s++)
               sum_p[s] <= sum_p[s-1];
         end
      end

      assign d = sum_p[DOT_LAT-2];
   end

endmodule

// File: rtl/tensor_thread_group.sv
// Thread group: GROUP_SIZE dot-product lanes sharing one A vector, a local tile memory
// for accumulate/write-back, and a scoreboard that interlocks tile read-after-write.
module tensor_thread_group
   import tensor_pkg::*;
#(
   parameter int XLEN          = XLEN_DEFAULT,
   parameter int GROUP_SIZE    = GROUP_SIZE_DEFAULT,
   parameter int DOT_LAT       = 2,
   parameter int NUM_TILE_BUFS = 2,
   parameter int NUM_TILE_REGS = 8
) (
   input logic                  clk,
   input logic                  reset,
   tensor_thread_group_if.slave io
);

   localparam int RD_W  = $clog2(NUM_TILE_BUFS) + $clog2(NUM_TILE_REGS);
   localparam int TILES = 2 ** RD_W;
   localparam int LAST  = DOT_LAT - 1;
   localparam int VEC_W = GROUP_SIZE * XLEN;

   // rd = {reg, buf}, so rd is directly the flat tile index reg*NUM_TILE_BUFS + buf.
   logic [VEC_W-1:0] tile_mem [TILES];

   logic [DOT_LAT-1:0] vld_p;
   logic [DOT_LAT-1:0] wb_p;
   logic [RD_W-1:0]    rd_p [DOT_LAT];

   logic             stall;
   logic             hazard;
   logic             accept;
   logic             commit;
   logic             valid_out;
   logic [VEC_W-1:0] acc_vec;
   logic [VEC_W-1:0] result;

   assign stall  = vld_p[LAST] && !wb_p[LAST] && !io.ready_out;
   assign commit = vld_p[LAST] && wb_p[LAST];

   always_comb begin
      hazard = 1'b0;
      for (int s = 0; s < DOT_LAT; s++)
         if (vld_p[s] && wb_p[s] && (rd_p[s] == io.rd)) hazard = 1'b1;
      hazard = hazard && io.acc_sel;
   end

   assign io.ready_in = !stall && !hazard;
   assign accept      = io.valid_in && io.ready_in;
   assign acc_vec     = io.acc_sel ? tile_mem[io.rd] : io.vec_c_in;

   for (genvar i = 0; i < GROUP_SIZE; i++) begin : g_lane
      dot_lane #(
         .XLEN      (XLEN),
         .GROUP_SIZE(GROUP_SIZE),
         .DOT_LAT   (DOT_LAT)
      ) u_lane (
         .clk  (clk),
         .stall(stall),
         .a    (io.vec_a_in),
         .b    (io.vec_b_in[i*VEC_W +: VEC_W]),
         .acc  (acc_vec[i*XLEN +: XLEN]),
         .d    (result[i*XLEN +: XLEN])
      );
   end

   // p0..pLAST: control shadow of the lane pipeline
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p <= '0;
      end else if (!stall) begin
         vld_p[0] <= accept;
         for (int s = 1; s < DOT_LAT; s++)
            vld_p[s] <= vld_p[s-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!stall) begin
         wb_p[0] <= io.wb;
         rd_p[0] <= io.rd;
         for (int s = 1; s < DOT_LAT; s++) begin
            wb_p[s] <= wb_p[s-1];
            rd_p[s] <= rd_p[s-1];
         end
      end
   end

   // Write-back retires from the final stage; reset wins so no commit escapes it.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int t = 0; t < TILES; t++)
            tile_mem[t] <= '0;
      end else if (commit) begin
         tile_mem[rd_p[LAST]] <= result;
      end
   end

   assign valid_out    = vld_p[LAST] && !wb_p[LAST];
   assign io.valid_out = valid_out;
   assign io.vec_d_out = valid_out ? result : '0;
   assign io.rd_out    = valid_out ? rd_p[LAST] : '0;

endmodule

// File: tb/tb_tensor_thread_group.sv
// Directed bench for tensor_thread_group with a reference model and an in-order result queue.
module tb_tensor_thread_group;

   localparam int XL  = 32;
   localparam int GS  = 4;
   localparam int LAT = 3;
   localparam int NB  = 2;
   localparam int NR  = 8;
   localparam int RW  = 4;

   typedef logic [GS*XL-1:0]    vec_t;
   typedef logic [GS*GS*XL-1:0] mat_t;
   typedef struct {
      logic [RW-1:0] rd;
      vec_t          d;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   tensor_thread_group_if #(.XLEN(XL), .GROUP_SIZE(GS), .RD_W(RW)) bus ();

   tensor_thread_group #(
      .XLEN(XL), .GROUP_SIZE(GS), .DOT_LAT(LAT), .NUM_TILE_BUFS(NB), .NUM_TILE_REGS(NR)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .io   (bus)
   );

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   out_cnt = 0;
   int   last_out_cyc = 0;
   int   last_acc_cyc = 0;
   exp_t sb[$];
   vec_t mtile [16];

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [GS*XL-1:0] got, input logic [GS*XL-1:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic vec_t vec4(input logic [XL-1:0] x0, x1, x2, x3);
      return {x3, x2, x1, x0};
   endfunction

   function automatic vec_t splat(input logic [XL-1:0] x);
      return {GS{x}};
   endfunction

   function automatic vec_t model_dot(input vec_t a, input mat_t b, input vec_t c);
      vec_t d;
      for (int i = 0; i < GS; i++) begin
         logic [XL-1:0] s;
         s = c[i*XL +: XL];
         for (int k = 0; k < GS; k++)
            s = s + a[k*XL +: XL] * b[(i*GS+k)*XL +: XL];
         d[i*XL +: XL] = s;
      end
      return d;
   endfunction

   // Output monitor: compare every transfer against the head of the queue.
   always @(negedge clk) begin
      if (!reset && bus.valid_out && bus.ready_out) begin
         checks++;
         assert (sb.size() != 0)
         else begin
            errors++;
            $error("FAIL unexpected_out got rd %0d with empty queue, expected none", bus.rd_out);
         end
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("d_out", bus.vec_d_out, e.d);
            chk("rd_out", GS*XL'(bus.rd_out), GS*XL'(e.rd));
         end
         out_cnt++;
         last_out_cyc = cyc;
      end
   end

   task automatic send(input vec_t a, input mat_t b, input vec_t c, input logic sel,
                       input logic w, input logic [RW-1:0] r, output int waited);
      vec_t acc;
      vec_t d;
      exp_t e;
      waited = 0;
      bus.valid_in = 1'b1;
      bus.vec_a_in = a;
      bus.vec_b_in = b;
      bus.vec_c_in = c;
      bus.acc_sel  = sel;
      bus.wb       = w;
      bus.rd       = r;
      @(negedge clk);
      while (!bus.ready_in && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      assert (bus.ready_in === 1'b1)
      else begin
         errors++;
         $error("FAIL accept_timeout got ready_in %b expected 1", bus.ready_in);
      end
      acc = sel ? mtile[r] : c;
      d   = model_dot(a, b, acc);
      if (w) mtile[r] = d;
      else begin
         e.rd = r;
         e.d  = d;
         sb.push_back(e);
      end
      last_acc_cyc = cyc;
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk(tag, GS*XL'(sb.size()), '0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int t = 0; t < 16; t++) mtile[t] = '0;
      sb.delete();
   endtask

   initial begin
      int   w;
      int   first_acc;
      mat_t ones;
      ones = {GS*GS{32'd1}};
      bus.valid_in  = 1'b0;
      bus.vec_a_in  = '0;
      bus.vec_b_in  = '0;
      bus.vec_c_in  = '0;
      bus.acc_sel   = 1'b0;
      bus.wb        = 1'b0;
      bus.rd        = '0;
      bus.ready_out = 1'b1;
      do_reset();

      @(negedge clk);
      chk("rst_valid_out", GS*XL'(bus.valid_out), '0);
      chk("rst_vec_d_out", bus.vec_d_out, '0);
      chk("rst_rd_out", GS*XL'(bus.rd_out), '0);
      chk("rst_ready_in", GS*XL'(bus.ready_in), GS*XL'(1));
      @(posedge clk);
      #1;

      // Basic dot product with external accumulator, checked with fixed latency.
      send(vec4(1, 2, 3, 4), ones, vec4(10, 20, 30, 40), 1'b0, 1'b0, 4'd2, w);
      repeat (LAT - 1) @(posedge clk);
      @(negedge clk);
      chk("lat_valid_out", GS*XL'(bus.valid_out), GS*XL'(1));
      chk("basic_d", bus.vec_d_out, vec4(20, 30, 40, 50));
      drain("drain_basic");

      // Wrap-around arithmetic.
      send(splat(32'hFFFF_FFFF), {GS*GS{32'd2}}, '0, 1'b0, 1'b0, 4'd9, w);
      drain("drain_wrap");

      // Write-back then dependent read of buf1/reg3.
      send(splat(1), ones, splat(1), 1'b0, 1'b1, 4'd7, w);
      send('0, ones, splat(99), 1'b1, 1'b0, 4'd7, w);
      chk("hazard_wait", GS*XL'(w), GS*XL'(LAT));
      drain("drain_hazard");
      chk("hazard_model", mtile[7], splat(5));

      // Neighbouring tile registers stay distinct.
      send(vec4(2, 0, 0, 0), ones, splat(3), 1'b0, 1'b1, 4'd6, w);
      send(vec4(0, 0, 0, 7), ones, splat(1), 1'b0, 1'b1, 4'd1, w);
      send('0, ones, '0, 1'b1, 1'b0, 4'd6, w);
      send('0, ones, '0, 1'b1, 1'b0, 4'd1, w);
      send(vec4(1, 1, 1, 1), ones, '0, 1'b1, 1'b0, 4'd7, w);
      drain("drain_tiles");

      // Stall with three in flight.
      bus.ready_out = 1'b0;
      send(vec4(1, 0, 0, 0), ones, splat(100), 1'b0, 1'b0, 4'd3, w);
      send(vec4(0, 2, 0, 0), ones, splat(200), 1'b0, 1'b0, 4'd4, w);
      send(vec4(0, 0, 3, 0), ones, splat(300), 1'b0, 1'b0, 4'd5, w);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid_out", GS*XL'(bus.valid_out), GS*XL'(1));
         chk("stall_d", bus.vec_d_out, splat(101));
         chk("stall_rd", GS*XL'(bus.rd_out), GS*XL'(3));
         chk("stall_ready_in", GS*XL'(bus.ready_in), '0);
         @(posedge clk);
         #1;
      end
      bus.ready_out = 1'b1;
      drain("drain_stall");

      // Reset one cycle before a write-back commits.
      send(splat(3), ones, splat(4), 1'b0, 1'b1, 4'd5, w);
      repeat (LAT - 1) @(posedge clk);
      #1;
      do_reset();
      @(negedge clk);
      chk("midrst_valid_out", GS*XL'(bus.valid_out), '0);
      chk("midrst_ready_in", GS*XL'(bus.ready_in), GS*XL'(1));
      @(posedge clk);
      #1;
      send('0, ones, splat(55), 1'b1, 1'b0, 4'd5, w);
      send('0, ones, splat(55), 1'b1, 1'b0, 4'd7, w);
      drain("drain_midrst");

      // Sixteen back-to-back independent requests.
      out_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         vec_t a;
         mat_t b;
         vec_t c;
         for (int k = 0; k < GS; k++) begin
            a[k*XL +: XL] = $urandom;
            c[k*XL +: XL] = $urandom;
         end
         for (int k = 0; k < GS*GS; k++) b[k*XL +: XL] = $urandom;
         send(a, b, c, 1'b0, 1'b0, RW'(i), w);
         if (i == 0) first_acc = last_acc_cyc;
      end
      drain("drain_b2b");
      chk("b2b_accept_span", GS*XL'(last_acc_cyc - first_acc), GS*XL'(15));
      chk("b2b_last_latency", GS*XL'(last_out_cyc - last_acc_cyc), GS*XL'(LAT));
      chk("b2b_out_count", GS*XL'(out_cnt), GS*XL'(16));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
